ascon_fsm_ctrl: RTL and testbench

- Moore-style controller that sequences the Ascon-128 permutation datapath.
- Drives the datapath's mux select, register enable, round number and XOR/output enables through the phases Initialisation (p12), Associated Data (p6), Plaintext (p6 per block) and Finalisation (p12).
- Sits in the top-level ascon wrapper beside the permutation datapath.
- Handshakes with the data source: one data_valid_i per 64-bit block.

---
 rtl/ascon_fsm_ctrl_pkg.sv | 23 ++
 rtl/ascon_fsm_ctrl_compteur_double_init.sv | 25 ++
 rtl/ascon_fsm_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ascon_fsm_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_fsm_ctrl_pkg.sv
// Shared types and round constants for the Ascon-128 permutation controller.
package ascon_fsm_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    WAIT_AD = 3'd2,
    AD      = 3'd3,
    WAIT_PT = 3'd4,
    PT      = 3'd5,
    FINAL   = 3'd6,
    END     = 3'd7
  } type_fsm_state;

  localparam logic [3:0] ROUND_P12_START = 4'd0;
  localparam logic [3:0] ROUND_P6_START  = 4'd6;
  localparam logic [3:0] ROUND_LAST      = 4'd11;

  function automatic logic [3:0] state_code(input type_fsm_state s);
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/ascon_fsm_ctrl_compteur_double_init.sv
// Round counter with two preset values (p12 start / p6 start), saturating at the last round.
module compteur_double_init
  import ascon_fsm_ctrl_pkg::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       en_i,
  input  logic       init_a_i,
  input  logic       init_b_i,
  output logic [3:0] cpt_o
);

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      cpt_o <= ROUND_P12_START;
    end else if (init_a_i) begin
      cpt_o <= ROUND_P12_START;
    end else if (init_b_i) begin
      cpt_o <= ROUND_P6_START;
    end else if (en_i && (cpt_o != ROUND_LAST)) begin
      cpt_o <= cpt_o + 4'd1;
    end
  end

endmodule

// File: rtl/ascon_fsm_ctrl.sv
// Moore controller sequencing the Ascon-128 permutation: INIT p12, AD p6, PT p6 per block, FINAL p12.
// Optional debug ports (state_dbg_o, blocks_left_dbg_o) exist only when ASCON_FSM_DEBUG_EN is defined.
module ascon_fsm_ctrl
  import ascon_fsm_ctrl_pkg::*;
#(
  parameter int NB_PT_BLOCKS = 4,
  parameter int NB_AD_BLOCKS = 1
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       sel_o,
  output logic       en_o,
  output logic [3:0] round_o,
  output logic       en_xor_key_o,
  output logic       en_xor_key_final_o,
  output logic       en_xor_data_o,
  output logic       en_xor_lsb_o,
  output logic       en_out_cipher_o,
  output logic       en_out_tag_o,
  output logic       data_req_o,
  output logic       cipher_valid_o,
  output logic       end_o
`ifdef ASCON_FSM_DEBUG_EN
  ,
  output logic [3:0] state_dbg_o,
  output logic [3:0] blocks_left_dbg_o
`endif
);

  // Handshake: a block is consumed on the rising edge where data_req_o and
  // data_valid_i are both 1; data_valid_i is a don't-care whenever data_req_o is 0.

  type_fsm_state state, next_state;
  logic [3:0]    round;
  logic [3:0]    blocks_left;
  logic          last_block;
  logic          init_a, init_b;
  logic          can_start;

  compteur_double_init u_round_cnt (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .en_i     (en_o),
    .init_a_i (init_a),
    .init_b_i (init_b),
    .cpt_o    (round)
  );

  assign round_o    = round;
  assign last_block = (blocks_left == 4'd1);
  assign can_start  = (state == IDLE) || (state == END);

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Counts AD blocks first, then is reloaded with the plaintext block count.
  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      blocks_left <= '0;
    end else if (start_i && can_start) begin
      blocks_left <= 4'(NB_AD_BLOCKS);
    end else if ((state == AD) && (round == ROUND_LAST)) begin
      blocks_left <= last_block ? 4'(NB_PT_BLOCKS) : blocks_left - 4'd1;
    end else if ((state == PT) && (round == ROUND_LAST)) begin
      blocks_left <= blocks_left - 4'd1;
    end
  end

  always_comb begin
    next_state         = state;
    init_a             = 1'b0;
    init_b             = 1'b0;
    sel_o              = 1'b0;
    en_o               = 1'b0;
    en_xor_key_o       = 1'b0;
    en_xor_key_final_o = 1'b0;
    en_xor_data_o      = 1'b0;
    en_xor_lsb_o       = 1'b0;
    en_out_cipher_o    = 1'b0;
    en_out_tag_o       = 1'b0;
    data_req_o         = 1'b0;
    cipher_valid_o     = 1'b0;
    end_o              = 1'b0;
    case (state)
      IDLE: begin
        init_a = 1'b1;
        if (start_i) next_state = INIT;
      end
      INIT: begin
        en_o  = 1'b1;
        sel_o = (round != ROUND_P12_START);
        if (round == ROUND_LAST) begin
          en_xor_key_o = 1'b1;
          init_b       = 1'b1;
          next_state   = WAIT_AD;
        end
      end
      WAIT_AD: begin
        data_req_o = 1'b1;
        init_b     = 1'b1;
        if (data_valid_i) next_state = AD;
      end
      AD: begin
        en_o          = 1'b1;
        sel_o         = 1'b1;
        en_xor_data_o = (round == ROUND_P6_START);
        if (round == ROUND_LAST) begin
          en_xor_lsb_o = last_block;
          init_b       = 1'b1;
          next_state   = last_block ? WAIT_PT : WAIT_AD;
        end
      end
      WAIT_PT: begin
        // The last plaintext block goes straight into the p12 finalisation.
        data_req_o = 1'b1;
        init_a     = data_valid_i && last_block;
        init_b     = !(data_valid_i && last_block);
        if (data_valid_i) next_state = last_block ? FINAL : PT;
      end
      PT: begin
        en_o            = 1'b1;
        sel_o           = 1'b1;
        en_xor_data_o   = (round == ROUND_P6_START);
        en_out_cipher_o = (round == ROUND_P6_START);
        cipher_valid_o  = (round == ROUND_P6_START + 4'd1);
        if (round == ROUND_LAST) begin
          init_b     = 1'b1;
          next_state = WAIT_PT;
        end
      end
      FINAL: begin
        en_o               = 1'b1;
        sel_o              = 1'b1;
        en_xor_data_o      = (round == ROUND_P12_START);
        en_xor_key_final_o = (round == ROUND_P12_START);
        en_out_cipher_o    = (round == ROUND_P12_START);
        cipher_valid_o     = (round == ROUND_P12_START + 4'd1);
        if (round == ROUND_LAST) begin
          en_xor_key_o = 1'b1;
          en_out_tag_o = 1'b1;
          init_a       = 1'b1;
          next_state   = END;
        end
      end
      END: begin
        end_o  = 1'b1;
        init_a = 1'b1;
        if (start_i) next_state = INIT;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef ASCON_FSM_DEBUG_EN
  assign state_dbg_o       = state_code(state);
  assign blocks_left_dbg_o = blocks_left;
`endif

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// Self-checking bench for ascon_fsm_ctrl: per-cycle expected trace built from the phase rules.
module tb_ascon_fsm_ctrl;

  localparam int NB_PT = 4;
  localparam int NB_AD = 1;
  localparam logic [14:0] MASK_ALL  = 15'h7FFF;
  localparam logic [14:0] MASK_WAIT = 15'h3FFF;  // sel is a don't-care while stalled
  localparam logic [14:0] MASK_END  = 15'h21FF;  // sel and round are don't-cares in END

  logic       clock_i = 1'b0;
  logic       resetb_i = 1'b0;
  logic       start_i = 1'b0;
  logic       data_valid_i = 1'b0;
  logic       sel_o, en_o;
  logic [3:0] round_o;
  logic       en_xor_key_o, en_xor_key_final_o, en_xor_data_o, en_xor_lsb_o;
  logic       en_out_cipher_o, en_out_tag_o, data_req_o, cipher_valid_o, end_o;
`ifdef ASCON_FSM_DEBUG_EN
  logic [3:0] state_dbg_o, blocks_left_dbg_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int total_stall;

  logic [14:0] exp_q[$];
  logic [14:0] mask_q[$];
  bit          valid_q[$];

  // ---------------- clock / reset ----------------
  always #5 clock_i = ~clock_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ascon_fsm_ctrl #(.NB_PT_BLOCKS(NB_PT), .NB_AD_BLOCKS(NB_AD)) dut (
    .clock_i            (clock_i),
    .resetb_i           (resetb_i),
    .start_i            (start_i),
    .data_valid_i       (data_valid_i),
    .sel_o              (sel_o),
    .en_o               (en_o),
    .round_o            (round_o),
    .en_xor_key_o       (en_xor_key_o),
    .en_xor_key_final_o (en_xor_key_final_o),
    .en_xor_data_o      (en_xor_data_o),
    .en_xor_lsb_o       (en_xor_lsb_o),
    .en_out_cipher_o    (en_out_cipher_o),
    .en_out_tag_o       (en_out_tag_o),
    .data_req_o         (data_req_o),
    .cipher_valid_o     (cipher_valid_o),
    .end_o              (end_o)
`ifdef ASCON_FSM_DEBUG_EN
    ,
    .state_dbg_o        (state_dbg_o),
    .blocks_left_dbg_o  (blocks_left_dbg_o)
`endif
  );

  function automatic logic [14:0] observed();
    return {sel_o, en_o, round_o, en_xor_key_o, en_xor_key_final_o, en_xor_data_o,
            en_xor_lsb_o, en_out_cipher_o, en_out_tag_o, data_req_o, cipher_valid_o, end_o};
  endfunction

  function automatic logic [14:0] mk(input logic sel, input logic en, input logic [3:0] rnd,
                                     input logic key, input logic keyf, input logic dat,
                                     input logic lsb, input logic cip, input logic tag,
                                     input logic req, input logic cv, input logic fin);
    return {sel, en, rnd, key, keyf, dat, lsb, cip, tag, req, cv, fin};
  endfunction

  // ---------------- reference model (phase-level trace) ----------------
  task automatic push_cycle(input logic [14:0] e, input bit v, input logic [14:0] m);
    exp_q.push_back(e);
    mask_q.push_back(m);
    valid_q.push_back(v);
  endtask

  // k stall cycles, then one cycle where the block is presented
  task automatic push_wait(input int k);
    for (int j = 0; j <= k; j++)
      push_cycle(mk(0, 0, 4'd6, 0, 0, 0, 0, 0, 0, 1, 0, 0), (j == k), MASK_WAIT);
    total_stall += k;
  endtask

  task automatic build_message(input int max_stall, input int forced_pt_stall);
    int k;
    exp_q.delete();
    mask_q.delete();
    valid_q.delete();
    total_stall = 0;
    for (int r = 0; r < 12; r++)
      push_cycle(mk(r != 0, 1, 4'(r), r == 11, 0, 0, 0, 0, 0, 0, 0, 0),
                 bit'($urandom_range(0, 1)), MASK_ALL);
    for (int b = 0; b < NB_AD; b++) begin
      push_wait(int'($urandom_range(0, max_stall)));
      for (int r = 6; r < 12; r++)
        push_cycle(mk(1, 1, 4'(r), 0, 0, r == 6, (r == 11) && (b == NB_AD - 1), 0, 0, 0, 0, 0),
                   bit'($urandom_range(0, 1)), MASK_ALL);
    end
    for (int p = 0; p < NB_PT - 1; p++) begin
      k = (p == 0 && forced_pt_stall >= 0) ? forced_pt_stall : int'($urandom_range(0, max_stall));
      push_wait(k);
      for (int r = 6; r < 12; r++)
        push_cycle(mk(1, 1, 4'(r), 0, 0, r == 6, 0, r == 6, 0, 0, r == 7, 0),
                   bit'($urandom_range(0, 1)), MASK_ALL);
    end
    push_wait(int'($urandom_range(0, max_stall)));
    for (int r = 0; r < 12; r++)
      push_cycle(mk(1, 1, 4'(r), r == 11, r == 0, r == 0, 0, r == 0, r == 11, 0, r == 1, 0),
                 bit'($urandom_range(0, 1)), MASK_ALL);
    for (int e = 0; e < 3; e++)
      push_cycle(mk(0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 0, 0, 1), bit'($urandom_range(0, 1)), MASK_END);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge with the DUT in IDLE or END; start_i noise outside END must be ignored.
  task automatic run_message(input string tag, output int lat, output int pulses);
    logic [14:0] act;
    lat = -1;
    pulses = 0;
    start_i = 1'b1;
    data_valid_i = bit'($urandom_range(0, 1));
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clock_i);
      @(negedge clock_i);
      act = observed();
      n_cmp++;
      if ((act & mask_q[i]) !== exp_q[i]) begin
        n_bad++;
        $display("FAIL %s cycle %0d: got %b required %b", tag, i, act & mask_q[i], exp_q[i]);
      end
      if (end_o === 1'b1 && lat < 0) lat = i;
      if (cipher_valid_o === 1'b1) pulses++;
      start_i = (exp_q[i][0] == 1'b0) && ($urandom_range(0, 7) == 0);
      data_valid_i = valid_q[i];
    end
    start_i = 1'b0;
    data_valid_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetb_i = 1'b0;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    n_cmp++;
    if (observed() !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_state: got %b required 0", observed());
    end
`ifdef ASCON_FSM_DEBUG_EN
    n_cmp++;
    if (state_dbg_o !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_state_dbg: got %0d required 0", state_dbg_o);
    end
`endif
    resetb_i = 1'b1;
    start_i = 1'b1;
    @(posedge clock_i);
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (5) @(posedge clock_i);
    @(negedge clock_i);
    n_cmp++;
    if ({en_o, round_o} !== {1'b1, 4'd5}) begin
      n_bad++;
      $display("FAIL init_round5: got en=%b round=%0d required en=1 round=5", en_o, round_o);
    end
    resetb_i = 1'b0;
    repeat (2) @(posedge clock_i);
    @(negedge clock_i);
    n_cmp++;
    if (observed() !== 15'd0) begin
      n_bad++;
      $display("FAIL mid_init_reset: got %b required 0", observed());
    end
    resetb_i = 1'b1;
    data_valid_i = 1'b1;
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    data_valid_i = 1'b0;
    n_cmp++;
    if (observed() !== 15'd0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got %b required 0", observed());
    end
  endtask

  task automatic test_full_message();
    int lat, pulses;
    build_message(0, -1);
    run_message("full_msg", lat, pulses);
    n_cmp++;
    if (lat != 12 + NB_AD * 7 + (NB_PT - 1) * 7 + 13) begin
      n_bad++;
      $display("FAIL latency: got %0d required %0d", lat, 12 + NB_AD * 7 + (NB_PT - 1) * 7 + 13);
    end
    n_cmp++;
    if (pulses != NB_PT) begin
      n_bad++;
      $display("FAIL cipher_pulses: got %0d required %0d", pulses, NB_PT);
    end
  endtask

  task automatic test_stall();
    int lat, pulses;
    build_message(2, 5);
    run_message("stall_msg", lat, pulses);
    n_cmp++;
    if (lat != 53 + total_stall) begin
      n_bad++;
      $display("FAIL stall_latency: got %0d required %0d", lat, 53 + total_stall);
    end
  endtask

  task automatic test_back_to_back();
    int lat, pulses;
    for (int m = 0; m < 3; m++) begin
      build_message(3, -1);
      run_message("b2b_msg", lat, pulses);
      n_cmp++;
      if (lat != 53 + total_stall) begin
        n_bad++;
        $display("FAIL b2b_latency msg %0d: got %0d required %0d", m, lat, 53 + total_stall);
      end
      n_cmp++;
      if (pulses != NB_PT) begin
        n_bad++;
        $display("FAIL b2b_pulses msg %0d: got %0d required %0d", m, pulses, NB_PT);
      end
    end
    repeat (4) @(posedge clock_i);
    @(negedge clock_i);
    n_cmp++;
    if ({end_o, en_o} !== 2'b10) begin
      n_bad++;
      $display("FAIL end_hold: got end=%b en=%b required end=1 en=0", end_o, en_o);
    end
  endtask

  initial begin
    test_reset();
    test_full_message();
    test_stall();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
